// File: rtl/intctrl_prio_n_if.sv
// CPU-side bus of the interrupt controller: chip-select register port,
// IACK handshake, active-low dtack and the encoded active-low IPL.
interface intctrl_prio_n_if;
  logic       cs, oe, we, ack, dtack;
  logic [5:0] adr;
  logic [7:0] data_i, data_o;
  logic [2:0] ipl;

  modport master (output cs, adr, oe, we, data_i, ack, input  data_o, dtack, ipl);
  modport slave  (input  cs, adr, oe, we, data_i, ack, output data_o, dtack, ipl);
endinterface

// File: rtl/intctrl_prio_n.sv
// Prioritised N-source interrupt controller for a 68000 bus: per-source level/mode/enable/vector,
// IPL encoding and IACK vector delivery. Optional software interrupts via INTCTRL_SWINT_EN.
module intctrl_prio_n #(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int VEC_BASE    = 64,
  parameter int SPUR_VEC    = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq,
  intctrl_prio_n_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, VEC, HOLD, REARM} state_e;

  state_e                            state_q, state_d;
  logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q, sync_d;
  logic [N_SRC-1:0][7:0]             vec_q, vec_d;
  logic [N_SRC-1:0][4:0]             cfg_q, cfg_d;
  logic [N_SRC-1:0]                  s, s_prev_q, pend_edge_q, pend_edge_d;
  logic [N_SRC-1:0]                  pending, elig, swint_v;
  logic [15:0]                       pend16, w1c16;
  logic [2:0]                        arb_lvl, arb_lvl_q, ipl_q, ipl_d;
  logic [3:0]                        arb_idx, arb_idx_q;
  logic [7:0]                        data_q, data_d, rdata, vec_win;
  logic                              dtack_q, dtack_d, ack_q;
  logic                              bus_acc, wr, iack_hit;

  assign s       = sync_q[SYNC_STAGES-1];
  assign bus_acc = (state_q == IDLE) && bus.cs && !bus.ack;
  assign wr      = bus_acc && bus.we;

`ifdef INTCTRL_SWINT_EN
  localparam logic [7:0] SW_MASK = (N_SRC >= 8) ? 8'hFF : 8'((1 << N_SRC) - 1);
  logic [7:0] swint_q, swint_d;

  always_comb begin
    swint_v = '0;
    for (int i = 0; i < N_SRC && i < 8; i++) swint_v[i] = swint_q[i];
    swint_d = swint_q;
    if (wr && bus.adr == 6'h31) swint_d = bus.data_i & SW_MASK;
    if (iack_hit && !arb_idx[3]) swint_d[arb_idx[2:0]] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) swint_q <= '0;
    else        swint_q <= swint_d;
`else
  assign swint_v = '0;
`endif

  // Pending view, eligibility and priority search (ties keep the lowest index).
  always_comb begin
    arb_lvl = '0;
    arb_idx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      pending[i] = cfg_q[i][3] ? pend_edge_q[i] : (s[i] & cfg_q[i][4]);
      elig[i]    = (pending[i] | swint_v[i]) && (cfg_q[i][2:0] != 3'd0);
      if (elig[i] && cfg_q[i][2:0] > arb_lvl) begin
        arb_lvl = cfg_q[i][2:0];
        arb_idx = 4'(i);
      end
    end
    vec_win = '0;
    for (int i = 0; i < N_SRC; i++)
      if (arb_idx == 4'(i)) vec_win = vec_q[i];
  end

  // The winner is only honoured if it still matches the level the CPU was shown.
  assign iack_hit = (state_q == VEC) && (arb_lvl != 3'd0) && (arb_lvl == ~ipl_q);

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], irq};
    vec_d  = vec_q;
    cfg_d  = cfg_q;
    w1c16  = '0;
    if (wr && bus.adr == 6'h20) w1c16 = {8'h00, bus.data_i};
    if (wr && bus.adr == 6'h21) w1c16 = {bus.data_i, 8'h00};
    for (int i = 0; i < N_SRC; i++) begin
      // Set term applied after the clear so a coincident edge survives W1C/IACK.
      pend_edge_d[i] = ((pend_edge_q[i]
                         & ~(w1c16[i] | (iack_hit && arb_idx == 4'(i))))
                        | (s[i] & ~s_prev_q[i]))
                       & cfg_q[i][4] & cfg_q[i][3];
      if (wr && bus.adr == {2'b00, 4'(i)}) vec_d[i] = bus.data_i;
      if (wr && bus.adr == {2'b01, 4'(i)}) cfg_d[i] = bus.data_i[4:0];
    end
  end

  always_comb begin
    pend16             = '0;
    pend16[N_SRC-1:0]  = pending;
    rdata              = '0;
    case (bus.adr[5:4])
      2'd0: for (int i = 0; i < N_SRC; i++)
              if (bus.adr[3:0] == 4'(i)) rdata = vec_q[i];
      2'd1: for (int i = 0; i < N_SRC; i++)
              if (bus.adr[3:0] == 4'(i)) rdata = {3'b000, cfg_q[i]};
      2'd2: begin
        if (bus.adr[3:0] == 4'h0) rdata = pend16[7:0];
        if (bus.adr[3:0] == 4'h1) rdata = pend16[15:8];
      end
      default: begin
        if (bus.adr[3:0] == 4'h0) rdata = {arb_idx_q, 1'b0, arb_lvl_q};
`ifdef INTCTRL_SWINT_EN
        if (bus.adr[3:0] == 4'h1) rdata = swint_q;
`endif
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    ipl_d   = ipl_q;
    dtack_d = dtack_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        ipl_d   = ~arb_lvl;
        dtack_d = !bus_acc;
        data_d  = (bus_acc && bus.oe) ? rdata : 8'h00;
        if (bus.ack && !ack_q) state_d = VEC;
      end
      VEC: begin
        data_d  = iack_hit ? vec_win : 8'(SPUR_VEC);
        dtack_d = 1'b0;
        state_d = HOLD;
      end
      HOLD: if (!bus.ack) begin
        ipl_d   = 3'b111;
        dtack_d = 1'b1;
        data_d  = 8'h00;
        state_d = REARM;
      end
      default: begin
        ipl_d   = ~arb_lvl;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      s_prev_q    <= '0;
      pend_edge_q <= '0;
      cfg_q       <= '0;
      for (int i = 0; i < N_SRC; i++) vec_q[i] <= 8'(VEC_BASE + i);
      arb_lvl_q   <= '0;
      arb_idx_q   <= '0;
      ipl_q       <= 3'b111;
      dtack_q     <= 1'b1;
      data_q      <= '0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      s_prev_q    <= s;
      pend_edge_q <= pend_edge_d;
      cfg_q       <= cfg_d;
      vec_q       <= vec_d;
      arb_lvl_q   <= arb_lvl;
      arb_idx_q   <= arb_idx;
      ipl_q       <= ipl_d;
      dtack_q     <= dtack_d;
      data_q      <= data_d;
      ack_q       <= bus.ack;
    end
  end

  assign bus.ipl    = ipl_q;
  assign bus.dtack  = dtack_q;
  assign bus.data_o = data_q;
endmodule
